// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN layer sequencer:
//   - state_e                : FSM state encoding (4 bits, also driven on the
//                              debug 'state' port)
//   - DEFAULT_TIMEOUT_CYCLES : default stage-wait limit
//   - is_start/is_wait/is_busy : state classification helpers used by the
//                              sequencer datapath and watchdog control
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1000000;
  localparam int unsigned STATE_W                = 32'd4;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CONV_START  = 4'd1,
    ST_CONV_WAIT   = 4'd2,
    ST_POOL_START  = 4'd3,
    ST_POOL_WAIT   = 4'd4,
    ST_DENSE_START = 4'd5,
    ST_DENSE_WAIT  = 4'd6,
    ST_DONE        = 4'd7,
    ST_ERROR       = 4'd8
  } state_e;

  // One-cycle states that fire a stage start pulse.
  function automatic logic is_start(input state_e s);
    logic r;
    case (s)
      ST_CONV_START, ST_POOL_START, ST_DENSE_START: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

  // States that wait for a stage done handshake (watched by the watchdog).
  function automatic logic is_wait(input state_e s);
    logic r;
    case (s)
      ST_CONV_WAIT, ST_POOL_WAIT, ST_DENSE_WAIT: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Every state that is part of an active run.
  function automatic logic is_busy(input state_e s);
    return is_start(s) | is_wait(s);
  endfunction

endpackage

// File: rtl/cnn_stage_watchdog.sv
// -----------------------------------------------------------------------------
// cnn_stage_watchdog
// Counts cycles spent in a stage-wait state and flags when the wait limit is
// reached.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : zero the counter (asserted the cycle before a wait state begins)
//   enable  : the current cycle is a wait cycle; count it
//   expired : this wait cycle is the TIMEOUT_CYCLES-th one
// -----------------------------------------------------------------------------
module cnn_stage_watchdog
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  // r_wait_cnt holds the number of wait cycles already completed, so the
  // current cycle is the last permitted one when it equals TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] r_wait_cnt;

  // Wait-cycle counter: cleared before each wait, saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= {WD_W{1'b0}};
    end else if (clear) begin
      r_wait_cnt <= {WD_W{1'b0}};
    end else if (enable && (r_wait_cnt != WD_MAX)) begin
      r_wait_cnt <= r_wait_cnt + WD_ONE;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Built only from the count register and the registered-state enable; it
  // feeds next-state logic, so it never reaches a port directly.
  assign expired = enable & (r_wait_cnt >= WD_LAST);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
// Walks one image through the conv -> pool -> dense stages, latches the
// dense-stage class, measures run length and traps stalled stages.
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   start              : classify request (honoured in IDLE and DONE only)
//   conv/pool/dense_done : stage completion, honoured only in the stage's wait
//   dense_result       : class from the dense stage (0=CAT, 1=DOG)
//   start_conv/pool/dense : one-cycle stage start pulses
//   busy, done, error  : run status levels
//   prediction         : last captured class
//   cycle_count        : length of the last completed run, in cycles
//   state              : current FSM state (debug)
// All outputs are flops; they are loaded from the next-state value so they
// line up cycle-for-cycle with the state register and cannot glitch.
// -----------------------------------------------------------------------------
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 32'd32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             conv_done,
  input  logic             pool_done,
  input  logic             dense_done,
  input  logic             dense_result,
  output logic             start_conv,
  output logic             start_pool,
  output logic             start_dense,
  output logic             busy,
  output logic             done,
  output logic             prediction,
  output logic             error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [3:0]       state
);

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_wd_clear;
  logic             w_wd_enable;
  logic             w_wd_expired;
  logic             w_finish;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_run_cnt_inc;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_prediction;
  logic             r_start_conv;
  logic             r_start_pool;
  logic             r_start_dense;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  // The counter is zeroed during each START cycle, which always directly
  // precedes the matching WAIT state.
  assign w_wd_clear  = is_start(r_state);
  assign w_wd_enable = is_wait(r_state);

  cnn_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic. A done input on the last permitted wait cycle is
  // checked before the watchdog, so it wins over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next_state = ST_CONV_START;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_CONV_START:  w_next_state = ST_CONV_WAIT;
      ST_CONV_WAIT: begin
        if (conv_done) begin
          w_next_state = ST_POOL_START;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERROR;
        end else begin
          w_next_state = ST_CONV_WAIT;
        end
      end
      ST_POOL_START:  w_next_state = ST_POOL_WAIT;
      ST_POOL_WAIT: begin
        if (pool_done) begin
          w_next_state = ST_DENSE_START;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERROR;
        end else begin
          w_next_state = ST_POOL_WAIT;
        end
      end
      ST_DENSE_START: w_next_state = ST_DENSE_WAIT;
      ST_DENSE_WAIT: begin
        if (dense_done) begin
          w_next_state = ST_DONE;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERROR;
        end else begin
          w_next_state = ST_DENSE_WAIT;
        end
      end
      // ERROR is sticky; only reset leaves it.
      ST_ERROR:       w_next_state = ST_ERROR;
      // Unreachable encodings are treated as a fault.
      default:        w_next_state = ST_ERROR;
    endcase
  end

  // Run completes on the DENSE_WAIT -> DONE transition.
  assign w_finish      = (r_state == ST_DENSE_WAIT) && (w_next_state == ST_DONE);
  assign w_run_cnt_inc = (r_run_cnt == RUN_MAX) ? r_run_cnt : (r_run_cnt + RUN_ONE);

  // Run-length counter: zeroed when a run is launched, counts every busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= {CNT_W{1'b0}};
    end else if (w_next_state == ST_CONV_START) begin
      r_run_cnt <= {CNT_W{1'b0}};
    end else if (is_busy(r_state)) begin
      r_run_cnt <= w_run_cnt_inc;
    end else begin
      r_run_cnt <= r_run_cnt;
    end
  end

  // Result capture: the stored count includes the final DENSE_WAIT cycle,
  // hence the incremented value. A timeout never reaches here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= {CNT_W{1'b0}};
      r_prediction  <= 1'b0;
    end else if (w_finish) begin
      r_cycle_count <= w_run_cnt_inc;
      r_prediction  <= dense_result;
    end else begin
      r_cycle_count <= r_cycle_count;
      r_prediction  <= r_prediction;
    end
  end

  // Output flops decoded from the next state, so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_conv  <= 1'b0;
      r_start_pool  <= 1'b0;
      r_start_dense <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_start_conv  <= (w_next_state == ST_CONV_START);
      r_start_pool  <= (w_next_state == ST_POOL_START);
      r_start_dense <= (w_next_state == ST_DENSE_START);
      r_busy        <= is_busy(w_next_state);
      r_done        <= (w_next_state == ST_DONE);
      r_error       <= (w_next_state == ST_ERROR);
    end
  end

  assign start_conv  = r_start_conv;
  assign start_pool  = r_start_pool;
  assign start_dense = r_start_dense;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign prediction  = r_prediction;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum cycles spent in any one stage-wait state before an error is declared.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of cycle_count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to classify one image; sampled every cycle.
REQ-006 The block SHALL have port conv_done, input, 1 bit: convolution stage complete.
REQ-007 The block SHALL have port pool_done, input, 1 bit: pooling stage complete.
REQ-008 The block SHALL have port dense_done, input, 1 bit: dense stage complete.
REQ-009 The block SHALL have port dense_result, input, 1 bit: dense-stage class (0=CAT, 1=DOG); valid while dense_done=1.
REQ-010 The block SHALL have port start_conv, output, 1 bit: one-cycle start pulse to the convolution stage.
REQ-011 The block SHALL have port start_pool, output, 1 bit: one-cycle start pulse to the pooling stage.
REQ-012 The block SHALL have port start_dense, output, 1 bit: one-cycle start pulse to the dense stage.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE, DONE and ERROR.
REQ-014 The block SHALL have port done, output, 1 bit: level, high while in DONE.
REQ-015 The block SHALL have port prediction, output, 1 bit: latched classification.
REQ-016 The block SHALL have port error, output, 1 bit: high while in ERROR.
REQ-017 The block SHALL have port cycle_count, output, CNT_W bits: cycles taken by the last completed run.
REQ-018 The block SHALL have port state, output, 4 bits: current FSM state, for debug.

Function
REQ-019 The FSM SHALL have the states IDLE, CONV_START, CONV_WAIT, POOL_START, POOL_WAIT, DENSE_START, DENSE_WAIT, DONE and ERROR, held in a 4-bit register.
REQ-020 In IDLE or DONE, start=1 SHALL cause the next state to be CONV_START; start in any other state SHALL be ignored.
REQ-021 Each X_START state SHALL last exactly one cycle, assert only its own start_x output, and then move to X_WAIT.
REQ-022 Transitions SHALL be: CONV_WAIT with conv_done -> POOL_START; POOL_WAIT with pool_done -> DENSE_START; DENSE_WAIT with dense_done -> DONE.
REQ-023 A done input SHALL be honoured only in its own WAIT state; all done inputs in other states, including the START cycle, SHALL be ignored.
REQ-024 On the DENSE_WAIT cycle with dense_done=1, prediction SHALL capture dense_result and SHALL then hold until the next capture.
REQ-025 Latency with zero-wait stages SHALL be: start sampled at edge T gives start_conv in cycle T+1 and done=1 first in cycle T+7.
REQ-026 A wait counter SHALL clear on entry to each WAIT state and increment once per WAIT cycle.
REQ-027 If TIMEOUT_CYCLES WAIT cycles elapse without the matching done, the next state SHALL be ERROR.
REQ-028 A done arriving on the final permitted wait cycle SHALL take priority over the timeout.
REQ-029 ERROR SHALL be left only by reset.
REQ-030 A run counter SHALL clear on entry to CONV_START and count every cycle from CONV_START through DENSE_WAIT inclusive.
REQ-031 cycle_count SHALL load the run counter value on entry to DONE (6 for zero-wait stages) and SHALL NOT change on a timeout.
REQ-032 Both counters SHALL saturate rather than wrap.
REQ-033 Outputs SHALL be decoded only from registered state, giving glitch-free pulses.

Reset
REQ-034 reset SHALL be synchronous, active-high, and SHALL take priority over every other input.
REQ-035 Reset SHALL force state=IDLE and all start_x, busy, done, error and prediction to 0, and cycle_count and both counters to 0.
REQ-036 Reset asserted mid-run SHALL abort the run; the cycle after reset deasserts SHALL be IDLE with no start pulse.

Structure
REQ-037 State encodings and the default TIMEOUT_CYCLES SHALL live in the shared package cnn_pkg.
REQ-038 The wait counter and timeout comparator SHALL be one sub-module, cnn_stage_watchdog (inputs clear and enable; output expired).

Verification
REQ-039 start pulse at T with each done returned the cycle after its start pulse SHALL give start_conv@T+1, start_pool@T+3, start_dense@T+5, done@T+7, cycle_count=6.
REQ-040 dense_result=1 at dense_done SHALL give prediction=1, held; a second run with dense_result=0 SHALL give prediction=0.
REQ-041 With TIMEOUT_CYCLES=8 and pool_done never asserted, the block SHALL enter ERROR after 8 POOL_WAIT cycles with error=1 and busy=0; start SHALL then be ignored; reset SHALL return it to IDLE.
REQ-042 With TIMEOUT_CYCLES=8 and conv_done on the 8th CONV_WAIT cycle, the next state SHALL be POOL_START with no error.
REQ-043 With conv_done held high permanently and a stray start during POOL_WAIT, pool_done and dense_done SHALL be unaffected, the stray start ignored, and exactly one start_conv pulse seen.
REQ-044 reset during DENSE_WAIT SHALL give all outputs 0 the next cycle, and a later start SHALL run a clean sequence.
